// File: rtl/uart_cmd_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_cmd_pkg
// Purpose  : Shared types and constants for the UART command dispatcher:
//            controller state encoding, response status bytes, NACK codes.
// Revision : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_DECODE   = 3'd2,
        ST_DISPATCH = 3'd3,
        ST_RESP0    = 3'd4,
        ST_RESP1    = 3'd5,
        ST_FLUSH    = 3'd6
    } state_t;

    localparam logic [7:0] ACK            = 8'h06;
    localparam logic [7:0] NACK           = 8'h15;
    localparam logic [7:0] CODE_OK        = 8'h00;
    localparam logic [7:0] CODE_FRAME_ERR = 8'h01;
    localparam logic [7:0] CODE_BAD_DEST  = 8'h02;
    localparam logic [7:0] CODE_TIMEOUT   = 8'h03;
    localparam logic [7:0] CODE_OVERRUN   = 8'h04;
    localparam logic [7:0] OPC_PING       = 8'h00;

    // Saturating 16-bit counter step; increment may be 0..3.
    function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_feed.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_cmd_feed
// Purpose  : Registers each received byte toward the accumulator, emits a
//            one-cycle accumulate strobe, holds the byte one extra cycle and
//            flags a byte that arrives while the previous one is still in
//            flight (overrun).
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_feed (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic [7:0] acc_data_o,
    output logic       acc_accumulate_o,
    output logic       accept_o,
    output logic       overrun_o
);

    logic [7:0] data_q;
    logic       pulse_q;
    logic       hold_q;
    logic       inflight;

    // A byte is in flight during its strobe cycle and the hold cycle after it.
    assign inflight  = pulse_q | hold_q;
    assign accept_o  = en_i & rx_valid_i & ~inflight;
    assign overrun_o = en_i & rx_valid_i & inflight;

    // Capture accepted bytes and sequence the strobe/hold pacing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= 8'h00;
            pulse_q <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            pulse_q <= accept_o;
            hold_q  <= pulse_q;
            if (accept_o) begin
                data_q <= rx_data_i;
            end
        end
    end

    assign acc_data_o       = data_q;
    assign acc_accumulate_o = pulse_q;

endmodule
`default_nettype wire

// File: rtl/uart_command_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_command_dispatcher
// Purpose  : Paces UART bytes into the command accumulator, decodes completed
//            frames, dispatches them to one of NUM_DEST consumers and returns
//            a two-byte ACK/NACK status to the UART transmitter.
// Options  : UART_CMD_DISPATCH_STATS_EN - enables frame_count / err_count.
// Revision : 1.0 - initial release
// ============================================================================
module uart_command_dispatcher #(
    parameter int NUM_DEST         = 4,
    parameter int DISPATCH_TIMEOUT = 2000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [7:0]          acc_data,
    output logic                acc_accumulate,
    output logic                acc_reset,
    input  logic [1023:0]       acc_output_data,
    input  logic [7:0]          acc_output_size,
    input  logic                acc_done,
    input  logic                acc_error,
    output logic                cmd_valid,
    output logic [NUM_DEST-1:0] cmd_sel,
    output logic [7:0]          cmd_opcode,
    output logic [1023:0]       cmd_payload,
    output logic [7:0]          cmd_len,
    input  logic [NUM_DEST-1:0] cmd_ready,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic [15:0]         frame_count,
    output logic [15:0]         err_count
);
    import uart_cmd_pkg::*;

    localparam int TW = $clog2(DISPATCH_TIMEOUT + 1);

    state_t                state_q;
    logic [7:0]            tx_data_q;
    logic                  tx_valid_q;
    logic [7:0]            code_q;
    logic                  nack_q;
    logic                  cmd_valid_q;
    logic [NUM_DEST-1:0]   cmd_sel_q;
    logic [7:0]            cmd_opcode_q;
    logic [7:0]            cmd_len_q;
    logic [1023:0]         cmd_payload_q;
    logic [TW-1:0]         timer_q;
    logic                  acc_reset_q;
    logic                  flush_q;
    logic                  err_prev_q;
    logic                  done_prev_q;

    logic                  feed_en;
    logic                  feed_accept;
    logic                  feed_overrun;
    logic                  err_rise;
    logic                  done_rise;
    logic                  xfer;
    logic                  timeout;
    logic                  bad_dest;
    logic [NUM_DEST-1:0]   dest_sel;

    assign feed_en   = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
    assign err_rise  = acc_error & ~err_prev_q;
    assign done_rise = acc_done & ~done_prev_q;
    // Only the ready bit of the selected destination can complete a transfer.
    assign xfer      = cmd_valid_q & (|(cmd_ready & cmd_sel_q));
    assign timeout   = (timer_q == TW'(DISPATCH_TIMEOUT - 1));
    assign bad_dest  = ({1'b0, cmd_opcode_q[2:0]} >= 4'(NUM_DEST));

    // One-hot destination decode from opcode[2:0].
    always_comb begin
        dest_sel = '0;
        for (int i = 0; i < NUM_DEST; i++) begin
            dest_sel[i] = (cmd_opcode_q[2:0] == 3'(i));
        end
    end

    uart_cmd_feed u_feed (
        .clk              (clk),
        .reset_n          (reset_n),
        .en_i             (feed_en),
        .rx_data_i        (rx_data),
        .rx_valid_i       (rx_valid),
        .acc_data_o       (acc_data),
        .acc_accumulate_o (acc_accumulate),
        .accept_o         (feed_accept),
        .overrun_o        (feed_overrun)
    );

    // Controller FSM with registered handshake, response and flush outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
            code_q        <= 8'h00;
            nack_q        <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_sel_q     <= '0;
            cmd_opcode_q  <= 8'h00;
            cmd_len_q     <= 8'h00;
            cmd_payload_q <= '0;
            timer_q       <= '0;
            acc_reset_q   <= 1'b1;
            flush_q       <= 1'b0;
            err_prev_q    <= 1'b0;
            done_prev_q   <= 1'b0;
        end else begin
            err_prev_q  <= acc_error;
            done_prev_q <= acc_done;
            case (state_q)
                ST_IDLE: begin
                    acc_reset_q <= 1'b0;
                    if (feed_accept) begin
                        state_q <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    // Error outranks a simultaneous completion.
                    if (err_rise) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= NACK;
                        nack_q     <= 1'b1;
                        code_q     <= CODE_FRAME_ERR;
                        state_q    <= ST_RESP0;
                    end else if (feed_overrun) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= NACK;
                        nack_q     <= 1'b1;
                        code_q     <= CODE_OVERRUN;
                        state_q    <= ST_RESP0;
                    end else if (done_rise) begin
                        cmd_opcode_q  <= acc_output_data[7:0];
                        cmd_len_q     <= acc_output_size;
                        cmd_payload_q <= acc_output_data;
                        state_q       <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (cmd_opcode_q == OPC_PING) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= ACK;
                        nack_q     <= 1'b0;
                        code_q     <= CODE_OK;
                        state_q    <= ST_RESP0;
                    end else if (bad_dest) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= NACK;
                        nack_q     <= 1'b1;
                        code_q     <= CODE_BAD_DEST;
                        state_q    <= ST_RESP0;
                    end else begin
                        cmd_valid_q <= 1'b1;
                        cmd_sel_q   <= dest_sel;
                        timer_q     <= '0;
                        state_q     <= ST_DISPATCH;
                    end
                end
                ST_DISPATCH: begin
                    // A transfer on the final allowed cycle still counts.
                    if (xfer) begin
                        cmd_valid_q <= 1'b0;
                        cmd_sel_q   <= '0;
                        tx_valid_q  <= 1'b1;
                        tx_data_q   <= ACK;
                        nack_q      <= 1'b0;
                        code_q      <= CODE_OK;
                        state_q     <= ST_RESP0;
                    end else if (timeout) begin
                        cmd_valid_q <= 1'b0;
                        cmd_sel_q   <= '0;
                        tx_valid_q  <= 1'b1;
                        tx_data_q   <= NACK;
                        nack_q      <= 1'b1;
                        code_q      <= CODE_TIMEOUT;
                        state_q     <= ST_RESP0;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_RESP0: begin
                    if (tx_ready) begin
                        tx_data_q <= code_q;
                        state_q   <= ST_RESP1;
                    end
                end
                ST_RESP1: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        if (nack_q) begin
                            acc_reset_q <= 1'b1;
                            flush_q     <= 1'b0;
                            state_q     <= ST_FLUSH;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_q) begin
                        acc_reset_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        flush_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef UART_CMD_DISPATCH_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] err_cnt_q;
    logic        ack_evt;
    logic        nack_evt;
    logic        drop_evt;

    assign ack_evt  = ((state_q == ST_DECODE) && (cmd_opcode_q == OPC_PING)) ||
                      ((state_q == ST_DISPATCH) && xfer);
    assign nack_evt = ((state_q == ST_COLLECT) && (err_rise || feed_overrun)) ||
                      ((state_q == ST_DECODE) && (cmd_opcode_q != OPC_PING) && bad_dest) ||
                      ((state_q == ST_DISPATCH) && !xfer && timeout);
    assign drop_evt = rx_valid && !feed_en;

    // Saturating ACK and NACK/dropped-byte counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= 16'h0000;
            err_cnt_q   <= 16'h0000;
        end else begin
            frame_cnt_q <= sat_add(frame_cnt_q, {1'b0, ack_evt});
            err_cnt_q   <= sat_add(err_cnt_q, {1'b0, nack_evt} + {1'b0, drop_evt});
        end
    end

    assign frame_count = frame_cnt_q;
    assign err_count   = err_cnt_q;
`else
    assign frame_count = 16'h0000;
    assign err_count   = 16'h0000;
`endif

    assign acc_reset   = acc_reset_q;
    assign cmd_valid   = cmd_valid_q;
    assign cmd_sel     = cmd_sel_q;
    assign cmd_opcode  = cmd_opcode_q;
    assign cmd_payload = cmd_payload_q;
    assign cmd_len     = cmd_len_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_command_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_command_dispatcher
// Purpose  : Self-checking bench for uart_command_dispatcher: table of
//            directed frames, randomized frames scored by a rule-level model,
//            reset and mid-dispatch reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_command_dispatcher;

    localparam int ND  = 4;
    localparam int TMO = 2000;
    localparam logic [7:0] S_ACK  = 8'h06;
    localparam logic [7:0] S_NACK = 8'h15;
`ifdef UART_CMD_DISPATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic [7:0]      acc_data;
    logic            acc_accumulate;
    logic            acc_reset;
    logic [1023:0]   acc_output_data;
    logic [7:0]      acc_output_size;
    logic            acc_done;
    logic            acc_error;
    logic            cmd_valid;
    logic [ND-1:0]   cmd_sel;
    logic [7:0]      cmd_opcode;
    logic [1023:0]   cmd_payload;
    logic [7:0]      cmd_len;
    logic [ND-1:0]   cmd_ready;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic            busy;
    logic [15:0]     frame_count;
    logic [15:0]     err_count;

    uart_command_dispatcher #(.NUM_DEST(ND), .DISPATCH_TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .acc_data(acc_data), .acc_accumulate(acc_accumulate), .acc_reset(acc_reset),
        .acc_output_data(acc_output_data), .acc_output_size(acc_output_size),
        .acc_done(acc_done), .acc_error(acc_error), .cmd_valid(cmd_valid),
        .cmd_sel(cmd_sel), .cmd_opcode(cmd_opcode), .cmd_payload(cmd_payload),
        .cmd_len(cmd_len), .cmd_ready(cmd_ready), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .frame_count(frame_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]    opc;
        int            len;
        int            rdy_dly;   // cycles of cmd_valid before ready; -1 = never
        int            err;       // 0 none, 1 acc_error, 2 acc_error with acc_done
        bit            ovr;       // second byte on the very next cycle
        bit            junk;      // hold the non-selected ready bits high
        bit            drop;      // extra rx byte while responding
        bit            exp_disp;
        logic [ND-1:0] exp_sel;
        logic [7:0]    exp_s0;
        logic [7:0]    exp_s1;
    } vec_t;

    int vectors     = 0;
    int miscompares = 0;
    int exp_frames  = 0;
    int exp_errs    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rx_data = 8'h00; rx_valid = 1'b0; acc_output_data = '0; acc_output_size = 8'h00;
        acc_done = 1'b0; acc_error = 1'b0; cmd_ready = '0; tx_ready = 1'b0;
    endtask

    task automatic recover();
        reset_n = 1'b0;
        clear_inputs();
        tick(); tick();
        reset_n = 1'b1;
        exp_frames = 0;
        exp_errs   = 0;
        tick();
    endtask

    function automatic vec_t mk(logic [7:0] opc, int len, int rdy, int err, bit ovr, bit junk,
                                bit drop, bit disp, logic [ND-1:0] sel, logic [7:0] s0, logic [7:0] s1);
        vec_t v;
        v.opc = opc; v.len = len; v.rdy_dly = rdy; v.err = err; v.ovr = ovr; v.junk = junk;
        v.drop = drop; v.exp_disp = disp; v.exp_sel = sel; v.exp_s0 = s0; v.exp_s1 = s1;
        return v;
    endfunction

    // Reference: outcome of a frame from the documented dispatch rules.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        r = v;
        r.exp_disp = 1'b0;
        r.exp_sel  = '0;
        if (v.ovr) begin
            r.exp_s0 = S_NACK; r.exp_s1 = 8'h04;
        end else if (v.err != 0) begin
            r.exp_s0 = S_NACK; r.exp_s1 = 8'h01;
        end else if (v.opc == 8'h00) begin
            r.exp_s0 = S_ACK;  r.exp_s1 = 8'h00;
        end else if (int'(v.opc % 8) >= ND) begin
            r.exp_s0 = S_NACK; r.exp_s1 = 8'h02;
        end else begin
            r.exp_disp = 1'b1;
            r.exp_sel  = ND'(1) << (v.opc % 8);
            if (v.rdy_dly >= 0 && v.rdy_dly < TMO) begin
                r.exp_s0 = S_ACK;  r.exp_s1 = 8'h00;
            end else begin
                r.exp_s0 = S_NACK; r.exp_s1 = 8'h03;
            end
        end
        return r;
    endfunction

    task automatic do_frame(input vec_t v, input string tag);
        logic [7:0]    b[$];
        logic [7:0]    got[$];
        logic [1023:0] pay;
        logic [7:0]    x;
        logic [ND-1:0] rdy_bits;
        int            n;
        int            cnt;
        int            exp_cyc;
        pay = '0;
        for (int i = 0; i < v.len; i++) begin
            x = (i == 0) ? v.opc : 8'($urandom);
            b.push_back(x);
            pay[i*8 +: 8] = x;
        end
        // byte feed
        if (v.ovr) begin
            rx_data = b[0]; rx_valid = 1'b1;
            tick();
            check({tag, "/ovr_pulse"}, {acc_accumulate, acc_data}, {1'b1, b[0]});
            rx_data = b[1];
            tick();
            rx_valid = 1'b0;
        end else begin
            for (int i = 0; i < v.len; i++) begin
                rx_data = b[i]; rx_valid = 1'b1;
                tick();
                rx_valid = 1'b0;
                check({tag, "/acc_pulse"}, {acc_accumulate, acc_data}, {1'b1, b[i]});
                tick();
                check({tag, "/acc_hold"}, {acc_accumulate, acc_data}, {1'b0, b[i]});
                tick();
            end
            check({tag, "/busy_collect"}, busy, 1'b1);
            if (v.err != 0) begin
                acc_error = 1'b1;
                if (v.err == 2) begin
                    acc_output_data = pay; acc_output_size = 8'(v.len); acc_done = 1'b1;
                end
            end else begin
                acc_output_data = pay; acc_output_size = 8'(v.len); acc_done = 1'b1;
            end
        end
        // wait for dispatch or response
        n = 0;
        while (!cmd_valid && !tx_valid && n < 20) begin tick(); n++; end
        if (!cmd_valid && !tx_valid) begin bound_fail({tag, "/first_out"}); recover(); return; end
        if (v.err == 0 && !v.ovr) check({tag, "/done_latency"}, 64'(n), 64'd2);
        check({tag, "/dispatch"}, cmd_valid, v.exp_disp);
        if (cmd_valid) begin
            check({tag, "/sel"}, cmd_sel, v.exp_sel);
            check({tag, "/opc_len"}, {cmd_opcode, cmd_len}, {v.opc, 8'(v.len)});
            vectors++;
            if (cmd_payload !== pay) begin
                miscompares++;
                $display("FAIL %s/payload: got %0h expected %0h", tag, cmd_payload[63:0], pay[63:0]);
            end
            cnt = 0;
            while (cmd_valid && cnt < TMO + 10) begin
                rdy_bits = v.junk ? ~v.exp_sel : '0;
                if (v.rdy_dly >= 0 && cnt >= v.rdy_dly) rdy_bits = rdy_bits | v.exp_sel;
                cmd_ready = rdy_bits;
                tick();
                cnt++;
            end
            cmd_ready = '0;
            exp_cyc = (v.rdy_dly >= 0 && v.rdy_dly < TMO) ? v.rdy_dly + 1 : TMO;
            check({tag, "/valid_cycles"}, 64'(cnt), 64'(exp_cyc));
            check({tag, "/tx_after_hs"}, {tx_valid, tx_data}, {1'b1, v.exp_s0});
        end
        // response collection with random back-pressure
        if (v.drop) begin
            tx_ready = 1'b0; rx_data = 8'hEE; rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0;
        end
        n = 0;
        while (got.size() < 2 && n < 60) begin
            tx_ready = 1'($urandom_range(0, 1));
            if (tx_valid && tx_ready) got.push_back(tx_data);
            tick();
            n++;
        end
        tx_ready = 1'b0;
        if (got.size() < 2) begin bound_fail({tag, "/response"}); recover(); return; end
        check({tag, "/status"}, {got[0], got[1]}, {v.exp_s0, v.exp_s1});
        // flush phase
        cnt = 0; n = 0;
        while (busy && n < 10) begin
            if (acc_reset) cnt++;
            tick();
            n++;
        end
        check({tag, "/flush_cycles"}, 64'(cnt), (v.exp_s0 == S_NACK) ? 64'd2 : 64'd0);
        check({tag, "/idle"}, {busy, acc_reset}, 2'b00);
        if (v.exp_s0 == S_ACK) exp_frames++; else exp_errs++;
        if (v.drop) exp_errs++;
        check({tag, "/frame_count"}, frame_count, STATS ? 16'(exp_frames) : 16'd0);
        check({tag, "/err_count"}, err_count, STATS ? 16'(exp_errs) : 16'd0);
        acc_done = 1'b0; acc_error = 1'b0; acc_output_data = '0; acc_output_size = 8'h00;
        tick(); tick();
    endtask

    vec_t tbl[13];

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vec_t v;
        reset_n = 1'b0;
        clear_inputs();
        tick(); tick();
        check("reset/ctrl", {busy, cmd_valid, cmd_sel, tx_valid, acc_accumulate, acc_reset}, {1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1});
        check("reset/data", {tx_data, acc_data, cmd_len, cmd_opcode}, 32'h0);
        check("reset/counts", {frame_count, err_count}, 32'h0);
        reset_n = 1'b1;
        tick();
        check("reset/acc_reset_release", acc_reset, 1'b0);

        //            opc    len rdy  err ovr junk drop disp sel      s0      s1
        tbl[0]  = mk(8'h01, 3,  0,   0,  0,  0,   0,   1,  4'b0010, S_ACK,  8'h00);
        tbl[1]  = mk(8'h00, 2,  0,   0,  0,  0,   0,   0,  4'b0000, S_ACK,  8'h00);
        tbl[2]  = mk(8'h07, 1,  0,   0,  0,  0,   0,   0,  4'b0000, S_NACK, 8'h02);
        tbl[3]  = mk(8'h0C, 2,  0,   0,  0,  0,   0,   0,  4'b0000, S_NACK, 8'h02);
        tbl[4]  = mk(8'h0B, 4,  5,   0,  0,  1,   0,   1,  4'b1000, S_ACK,  8'h00);
        tbl[5]  = mk(8'h0A, 2, -1,   0,  0,  0,   0,   1,  4'b0100, S_NACK, 8'h03);
        tbl[6]  = mk(8'h02, 1, 1999, 0,  0,  1,   0,   1,  4'b0100, S_ACK,  8'h00);
        tbl[7]  = mk(8'h01, 2,  0,   1,  0,  0,   0,   0,  4'b0000, S_NACK, 8'h01);
        tbl[8]  = mk(8'h03, 2,  0,   2,  0,  0,   0,   0,  4'b0000, S_NACK, 8'h01);
        tbl[9]  = mk(8'h05, 2,  0,   0,  1,  0,   0,   0,  4'b0000, S_NACK, 8'h04);
        tbl[10] = mk(8'h09, 3,  3,   0,  0,  1,   1,   1,  4'b0010, S_ACK,  8'h00);
        tbl[11] = mk(8'h00, 1,  0,   0,  0,  0,   1,   0,  4'b0000, S_ACK,  8'h00);
        tbl[12] = mk(8'h08, 5,  0,   0,  0,  0,   0,   1,  4'b0001, S_ACK,  8'h00);
        for (int i = 0; i < 13; i++) begin
            do_frame(tbl[i], $sformatf("tbl%0d", i));
        end

        for (int k = 0; k < 25; k++) begin
            v.opc = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) v.opc = {5'($urandom), 3'($urandom_range(0, ND - 1))};
            v.len     = int'($urandom_range(1, 6));
            v.rdy_dly = ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(0, 6));
            v.err     = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
            v.ovr     = (v.err == 0) && (v.len >= 2) && ($urandom_range(0, 9) == 0);
            v.junk    = 1'($urandom_range(0, 1));
            v.drop    = ($urandom_range(0, 5) == 0);
            v = model(v);
            do_frame(v, $sformatf("rand%0d", k));
        end

        // reset asserted while a command is waiting for ready
        rx_data = 8'h02; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick(); tick();
        acc_output_data = 1024'h02; acc_output_size = 8'd1; acc_done = 1'b1;
        n = 0;
        while (!cmd_valid && n < 10) begin tick(); n++; end
        check("midrst/pre_valid", cmd_valid, 1'b1);
        tick();
        #1 reset_n = 1'b0;
        #1;
        check("midrst/ctrl", {busy, cmd_valid, cmd_sel, tx_valid, acc_accumulate, acc_reset}, {1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1});
        check("midrst/data", {tx_data, acc_data, cmd_len, cmd_opcode, 7'h0, |cmd_payload}, 40'h0);
        check("midrst/counts", {frame_count, err_count}, 32'h0);
        clear_inputs();
        tick(); tick();
        reset_n = 1'b1;
        exp_frames = 0;
        exp_errs   = 0;
        tick();
        check("midrst/release", {busy, acc_reset}, 2'b00);
        do_frame(tbl[0], "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_command_dispatcher.md
# uart_command_dispatcher

Controller that sequences the UART command accumulator and routes completed frames. It sits between the UART receiver and the accumulator. It paces received bytes into the accumulator and watches for frame completion or error. It decodes the opcode byte, hands the frame to one of `NUM_DEST` command consumers over a valid/ready handshake, and returns a two-byte status response to the UART transmitter.

## Interface
- `NUM_DEST`, 4: number of command consumers (1–8).
- `DISPATCH_TIMEOUT`, 2000: maximum cycles `cmd_valid` may wait for ready.
- `clk` in 1: sole clock; all logic rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte, valid with `rx_valid`.
- `rx_valid` in 1: one-cycle strobe per received byte.
- `acc_data` out 8: byte presented to the accumulator.
- `acc_accumulate` out 1: accumulate strobe to the accumulator.
- `acc_reset` out 1: active-high reset to the accumulator.
- `acc_output_data` in 1024: accumulated frame; first byte in [7:0].
- `acc_output_size` in 8: frame byte count.
- `acc_done` in 1: accumulator idle/complete flag.
- `acc_error` in 1: accumulator error flag.
- `cmd_valid` out 1: command available.
- `cmd_sel` out NUM_DEST: one-hot destination.
- `cmd_opcode` out 8: opcode byte.
- `cmd_payload` out 1024: full frame, opcode included.
- `cmd_len` out 8: frame byte count.
- `cmd_ready` in NUM_DEST: per-destination ready.
- `tx_data` out 8: response byte.
- `tx_valid` out 1: response byte valid.
- `tx_ready` in 1: transmitter accepts byte.
- `busy` out 1: high in any state except IDLE.
- `frame_count` out 16: frames acknowledged.
- `err_count` out 16: frames NACKed.

## Operation
- States: IDLE, COLLECT, DECODE, DISPATCH, RESP0, RESP1, FLUSH.
- **IDLE / COLLECT (byte feed)**
  - Each `rx_valid` byte is registered and driven on `acc_data`.
  - `acc_accumulate` pulses high for one cycle.
  - `acc_data` is held for that cycle plus one more.
  - The first byte moves IDLE→COLLECT.
- **Overrun**
  - Applies when `rx_valid` arrives during the hold cycle.
  - The byte is dropped; response is NACK code 0x04; go to RESP0.
- **COLLECT completion**
  - A registered rising edge of `acc_error` gives NACK code 0x01 → RESP0.
  - A registered rising edge of `acc_done` captures opcode, size and payload → DECODE.
- **DECODE**
  - Opcode 0x00 is a ping: ACK without dispatch → RESP0.
  - Otherwise dest = opcode[2:0].
  - dest ≥ NUM_DEST gives NACK code 0x02 → RESP0.
  - Otherwise → DISPATCH.
- **DISPATCH**
  - `cmd_valid`=1 with `cmd_sel`=1<<dest; all `cmd_*` outputs stable while waiting.
  - Transfer completes on the cycle where `cmd_valid` and `cmd_ready[dest]` are both high → ACK.
  - Only `cmd_ready[dest]` counts; other ready bits are ignored.
  - After `DISPATCH_TIMEOUT` cycles without transfer: drop `cmd_valid`, NACK code 0x03.
- **RESP0 / RESP1**
  - RESP0 sends status 0x06 (ACK) or 0x15 (NACK).
  - RESP1 sends the code (0x00 for ACK).
  - Each byte holds `tx_valid` until `tx_ready`; there is no timeout.
- **FLUSH**
  - Entered after any NACK.
  - `acc_reset` is high for 2 cycles, then → IDLE.
  - After ACK, go directly to IDLE.
- **Dropped input**
  - `rx_valid` in DECODE, DISPATCH, RESP0, RESP1 or FLUSH is dropped.
  - Each such byte increments `err_count`.
- **Counters**: increment once per ACK/NACK and saturate at 0xFFFF.

## Timing
- **Reset values**
  - `busy`, `cmd_valid`, `cmd_sel`, `tx_valid`, `acc_accumulate` = 0.
  - `acc_reset` = 1 while `reset_n` is low, then 0.
  - All data outputs and counters = 0.
- **Latencies**
  - `rx_valid` at cycle N → `acc_accumulate` at N+1.
  - `acc_done` edge sampled at N → DECODE at N+1 → `cmd_valid` at N+2.
  - Handshake at N → `tx_valid` at N+1.
- **Simultaneous events**
  - `acc_error` and `acc_done` rising in the same cycle: error wins.
  - `cmd_ready` on the timeout cycle: transfer wins.
- **Mid-operation reset**: `reset_n` low at any time aborts the operation immediately and resets all state and outputs.

## Configuration
- `UART_CMD_DISPATCH_STATS_EN`
  - Defined: `frame_count`/`err_count` are live.
  - Undefined: both outputs are tied to 0 and no counter flops exist.
  - Handshake behaviour is identical either way.

## Structure
- Shared package `uart_cmd_pkg` holds:
  - the state enum;
  - `ACK`=0x06 and `NACK`=0x15;
  - the NACK codes (0x01 frame error, 0x02 bad dest, 0x03 dispatch timeout, 0x04 overrun);
  - `OPC_PING`=0x00.
- One sub-module, `uart_cmd_feed`, owns:
  - the byte register;
  - the accumulate pulse/hold pacing;
  - overrun detection.

## Test plan
- Bytes 0x01,0x11,0x22 are fed, then the accumulator raises `acc_done` with size 3 → `cmd_valid`, `cmd_sel`=0b0010, `cmd_len`=3; `cmd_ready[1]` → tx 0x06,0x00; `frame_count`=1.
- Frame with opcode 0x00 → no `cmd_valid`; tx 0x06,0x00.
- Opcode 0x07 with `NUM_DEST`=4 → tx 0x15,0x02; `acc_reset` high for 2 cycles.
- `cmd_ready` held low → `cmd_valid` drops after 2000 cycles; tx 0x15,0x03; `err_count`=1.
- `acc_error` rising mid-frame → tx 0x15,0x01.
- `rx_valid` on two consecutive cycles → tx 0x15,0x04.
- `reset_n` pulsed during DISPATCH → all outputs return to reset values the same cycle.
